vram_arbiter: RTL and testbench

- Shares the single 8-bit static RAM between three requesters: the screen fetcher, the Z80 CPU and an auxiliary master (loader/DMA).
- Divides time into fixed 4-cycle slots of clk28 and grants each slot to at most one requester.
- Drives the RAM address, data and strobes, and returns read data plus a one-cycle acknowledge to the slot owner.
- Gives the CPU a wait/contention indication and the screen fetcher its fetch_allow.

---
 rtl/vram_arbiter_pkg.sv | 20 ++
 rtl/vram_slot_sel.sv | 45 ++++
 rtl/vram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the VRAM slot arbiter.
package vram_arbiter_pkg;

  // Slot owner encoding; IDLE means no RAM cycle in that slot.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_SCR  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_AUX  = 2'd3
  } owner_t;

  localparam int unsigned SLOT_LEN   = 4;
  localparam int unsigned PH_W       = 2;
  // Write strobe window inside a slot (phases inclusive).
  localparam int unsigned WE_START   = 1;
  localparam int unsigned WE_END     = 2;
  localparam int unsigned STARVE_W   = 3;
  localparam int unsigned STARVE_SAT = 7;

endpackage

// File: rtl/vram_slot_sel.sv
// Next-slot owner pick: CPU starvation override, then screen, then
// CPU/AUX round robin, then any single requester.
// Ports:
//   scr_req, cpu_req, aux_req : eligible requests at the slot boundary
//   starve                    : consecutive slots the CPU has lost
//   rr                        : round-robin pointer (0 -> CPU, 1 -> AUX)
//   next_owner_c              : owner for the following slot
//   rr_adv_c                  : tie was resolved by rr; pointer must toggle
module vram_slot_sel
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                scr_req,
  input  logic                cpu_req,
  input  logic                aux_req,
  input  logic [STARVE_W-1:0] starve,
  input  logic                rr,
  output owner_t              next_owner_c,
  output logic                rr_adv_c
);

  logic starve_hit_c;

  // STARVE_MAX of zero disables the override entirely.
  assign starve_hit_c = (STARVE_MAX != 0) && (32'(starve) >= STARVE_MAX);

  always_comb begin
    next_owner_c = OWN_IDLE;
    rr_adv_c     = 1'b0;
    if (cpu_req && starve_hit_c) begin
      next_owner_c = OWN_CPU;
    end else if (scr_req) begin
      next_owner_c = OWN_SCR;
    end else if (cpu_req && aux_req) begin
      next_owner_c = rr ? OWN_AUX : OWN_CPU;
      rr_adv_c     = 1'b1;
    end else if (cpu_req) begin
      next_owner_c = OWN_CPU;
    end else if (aux_req) begin
      next_owner_c = OWN_AUX;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slotted arbiter sharing one 8-bit SRAM between the screen fetcher,
// the Z80 CPU and an auxiliary master. Each 4-cycle slot of clk28 belongs to
// at most one owner, chosen on the last phase of the previous slot.
// Ports:
//   clk28, rst_n                   : clock, async active-low reset
//   scr_req/scr_addr               : screen fetch request (read only)
//   cpu_req/wr/addr/wdata          : CPU request, held until cpu_ack
//   aux_req/wr/addr/wdata          : auxiliary master request
//   fetch_allow                    : current slot is screen-owned
//   rdata                          : read data captured at slot end
//   scr_valid, cpu_ack, aux_ack    : one-cycle completion pulses
//   cpu_wait                       : contention indication to the CPU
//   ra, rd_o, rd_oe, rd_i          : SRAM address and data bus
//   ram_oe_n, ram_we_n             : SRAM strobes, active low
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              scr_req,
  input  logic [ADDR_W-1:0] scr_addr,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              aux_req,
  input  logic              aux_wr,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              fetch_allow,
  output logic [7:0]        rdata,
  output logic              scr_valid,
  output logic              cpu_ack,
  output logic              aux_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ra,
  output logic [7:0]        rd_o,
  output logic              rd_oe,
  input  logic [7:0]        rd_i,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  logic [PH_W-1:0]     ph, ph_d, ph_nxt;
  owner_t              owner, owner_d;
  logic                wr, wr_d;
  logic [STARVE_W-1:0] starve, starve_d;
  logic                rr, rr_d;
  logic [ADDR_W-1:0]   ra_d;
  logic [7:0]          rd_o_d, rdata_d;
  logic                rd_oe_d, ram_oe_n_d, ram_we_n_d;
  logic                scr_valid_d, cpu_ack_d, aux_ack_d;
  logic                fetch_allow_d, cpu_wait_d;

  logic                slot_end;
  logic                cpu_elig, aux_elig;
  owner_t              sel_owner_c;
  logic                rr_adv_c;

  assign slot_end = (ph == PH_W'(SLOT_LEN - 1));
  assign ph_nxt   = ph + PH_W'(1);

  // A requester finishing in this slot still holds req; it must not re-win now.
  assign cpu_elig = cpu_req && (owner != OWN_CPU);
  assign aux_elig = aux_req && (owner != OWN_AUX);

  vram_slot_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_slot_sel (
    .scr_req      (scr_req),
    .cpu_req      (cpu_elig),
    .aux_req      (aux_elig),
    .starve       (starve),
    .rr           (rr),
    .next_owner_c (sel_owner_c),
    .rr_adv_c     (rr_adv_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    ph_d          = ph_nxt;
    owner_d       = owner;
    wr_d          = wr;
    starve_d      = starve;
    rr_d          = rr;
    ra_d          = ra;
    rd_o_d        = rd_o;
    rdata_d       = rdata;
    rd_oe_d       = rd_oe;
    ram_oe_n_d    = ram_oe_n;
    scr_valid_d   = 1'b0;
    cpu_ack_d     = 1'b0;
    aux_ack_d     = 1'b0;
    fetch_allow_d = fetch_allow;
    // Write strobe only inside the window, leaving setup/hold at slot edges.
    ram_we_n_d    = !(wr && (ph_nxt >= PH_W'(WE_START)) && (ph_nxt <= PH_W'(WE_END)));
    cpu_wait_d    = cpu_req && !((owner == OWN_CPU) && slot_end);

    if (slot_end) begin
      // Close the ending slot.
      if ((owner != OWN_IDLE) && !wr) begin
        rdata_d = rd_i;
      end
      case (owner)
        OWN_SCR: scr_valid_d = 1'b1;
        OWN_CPU: cpu_ack_d   = 1'b1;
        OWN_AUX: aux_ack_d   = 1'b1;
        default: ;
      endcase

      // Open the next slot.
      owner_d       = sel_owner_c;
      fetch_allow_d = (sel_owner_c == OWN_SCR);
      wr_d          = 1'b0;
      rd_oe_d       = 1'b0;
      ram_oe_n_d    = 1'b1;
      if (rr_adv_c) begin
        rr_d = !rr;
      end
      if (cpu_elig && (sel_owner_c != OWN_CPU)) begin
        if (starve != STARVE_W'(STARVE_SAT)) begin
          starve_d = starve + STARVE_W'(1);
        end
      end else begin
        starve_d = '0;
      end

      case (sel_owner_c)
        OWN_SCR: begin
          ra_d       = scr_addr;
          ram_oe_n_d = 1'b0;
        end
        OWN_CPU: begin
          ra_d       = cpu_addr;
          wr_d       = cpu_wr;
          rd_o_d     = cpu_wdata;
          rd_oe_d    = cpu_wr;
          ram_oe_n_d = cpu_wr;
        end
        OWN_AUX: begin
          ra_d       = aux_addr;
          wr_d       = aux_wr;
          rd_o_d     = aux_wdata;
          rd_oe_d    = aux_wr;
          ram_oe_n_d = aux_wr;
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ph          <= '0;
      owner       <= OWN_IDLE;
      wr          <= 1'b0;
      starve      <= '0;
      rr          <= 1'b0;
      ra          <= '0;
      rd_o        <= '0;
      rdata       <= '0;
      rd_oe       <= 1'b0;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      scr_valid   <= 1'b0;
      cpu_ack     <= 1'b0;
      aux_ack     <= 1'b0;
      fetch_allow <= 1'b0;
      cpu_wait    <= 1'b0;
    end else begin
      ph          <= ph_d;
      owner       <= owner_d;
      wr          <= wr_d;
      starve      <= starve_d;
      rr          <= rr_d;
      ra          <= ra_d;
      rd_o        <= rd_o_d;
      rdata       <= rdata_d;
      rd_oe       <= rd_oe_d;
      ram_oe_n    <= ram_oe_n_d;
      ram_we_n    <= ram_we_n_d;
      scr_valid   <= scr_valid_d;
      cpu_ack     <= cpu_ack_d;
      aux_ack     <= aux_ack_d;
      fetch_allow <= fetch_allow_d;
      cpu_wait    <= cpu_wait_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reads, writes, screen starvation override
// (and its disabled variant), CPU/AUX alternation and mid-slot reset.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W = 19;

  logic              clk28 = 1'b0;
  logic              rst_n;
  logic              scr_req, cpu_req, cpu_wr, aux_req, aux_wr;
  logic [ADDR_W-1:0] scr_addr, cpu_addr, aux_addr;
  logic [7:0]        cpu_wdata, aux_wdata, rd_i;

  logic              fetch_allow, scr_valid, cpu_ack, aux_ack, cpu_wait;
  logic              rd_oe, ram_oe_n, ram_we_n;
  logic [7:0]        rdata, rd_o;
  logic [ADDR_W-1:0] ra;

  logic              fetch_allow0, scr_valid0, cpu_ack0, aux_ack0, cpu_wait0;
  logic              rd_oe0, ram_oe_n0, ram_we_n0;
  logic [7:0]        rdata0, rd_o0;
  logic [ADDR_W-1:0] ra0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk28 = ~clk28;

  vram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .scr_req(scr_req), .scr_addr(scr_addr),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .fetch_allow(fetch_allow), .rdata(rdata), .scr_valid(scr_valid),
    .cpu_ack(cpu_ack), .aux_ack(aux_ack), .cpu_wait(cpu_wait),
    .ra(ra), .rd_o(rd_o), .rd_oe(rd_oe), .rd_i(rd_i),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  vram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(0)) dut0 (
    .clk28(clk28), .rst_n(rst_n),
    .scr_req(scr_req), .scr_addr(scr_addr),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .fetch_allow(fetch_allow0), .rdata(rdata0), .scr_valid(scr_valid0),
    .cpu_ack(cpu_ack0), .aux_ack(aux_ack0), .cpu_wait(cpu_wait0),
    .ra(ra0), .rd_o(rd_o0), .rd_oe(rd_oe0), .rd_i(rd_i),
    .ram_oe_n(ram_oe_n0), .ram_we_n(ram_we_n0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    scr_req = 0; cpu_req = 0; cpu_wr = 0; aux_req = 0; aux_wr = 0;
    scr_addr = '0; cpu_addr = '0; aux_addr = '0;
    cpu_wdata = '0; aux_wdata = '0; rd_i = 8'hA5;

    // Reset state
    tick(3);
    chk("rst ra", 32'(ra), 0);
    chk("rst oe_n", 32'(ram_oe_n), 1);
    chk("rst we_n", 32'(ram_we_n), 1);
    chk("rst rd_oe", 32'(rd_oe), 0);
    chk("rst rdata", 32'(rdata), 0);
    chk("rst fetch", 32'(fetch_allow), 0);
    chk("rst wait", 32'(cpu_wait), 0);
    rst_n = 1'b1;  // ph = 0 from here

    // CPU read of 0x12345
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h12345;
    tick(3);
    chk("rd pregrant oe_n", 32'(ram_oe_n), 1);
    chk("rd pregrant wait", 32'(cpu_wait), 1);
    tick(1);
    chk("rd ra", 32'(ra), 32'h12345);
    chk("rd oe_n ph0", 32'(ram_oe_n), 0);
    chk("rd we_n ph0", 32'(ram_we_n), 1);
    chk("rd ack early", 32'(cpu_ack), 0);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      chk("rd oe_n slot", 32'(ram_oe_n), 0);
      chk("rd we_n slot", 32'(ram_we_n), 1);
    end
    chk("rd wait ph3", 32'(cpu_wait), 1);
    tick(1);
    chk("rd ack", 32'(cpu_ack), 1);
    chk("rd rdata", 32'(rdata), 32'hA5);
    chk("rd wait drop", 32'(cpu_wait), 0);
    chk("rd oe_n end", 32'(ram_oe_n), 1);
    cpu_req = 0;
    tick(1);
    chk("rd ack pulse", 32'(cpu_ack), 0);

    // CPU write 0x3C to 0x00010
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h00010; cpu_wdata = 8'h3C;
    tick(3);
    chk("wr rd_oe ph0", 32'(rd_oe), 1);
    chk("wr rd_o", 32'(rd_o), 32'h3C);
    chk("wr ra", 32'(ra), 32'h10);
    chk("wr we_n ph0", 32'(ram_we_n), 1);
    chk("wr oe_n", 32'(ram_oe_n), 1);
    tick(1);
    chk("wr we_n ph1", 32'(ram_we_n), 0);
    tick(1);
    chk("wr we_n ph2", 32'(ram_we_n), 0);
    tick(1);
    chk("wr we_n ph3", 32'(ram_we_n), 1);
    chk("wr rd_oe ph3", 32'(rd_oe), 1);
    tick(1);
    chk("wr ack", 32'(cpu_ack), 1);
    chk("wr rd_oe end", 32'(rd_oe), 0);
    cpu_req = 0; cpu_wr = 0;
    tick(1);
    chk("wr ack pulse", 32'(cpu_ack), 0);

    // Screen held, CPU starving: override after 3 screen slots
    scr_req = 1; scr_addr = 19'h04000;
    cpu_req = 1; cpu_addr = 19'h0ABCD; rd_i = 8'h5A;
    tick(3);
    chk("sv fetch s1", 32'(fetch_allow), 1);
    chk("sv ra scr", 32'(ra), 32'h04000);
    tick(4);
    chk("sv fetch s2", 32'(fetch_allow), 1);
    chk("sv scr_valid", 32'(scr_valid), 1);
    tick(4);
    chk("sv fetch s3", 32'(fetch_allow), 1);
    tick(4);
    chk("sv fetch cpu slot", 32'(fetch_allow), 0);
    chk("sv ra cpu", 32'(ra), 32'h0ABCD);
    chk("sv starve clr", 32'(dut.starve), 0);
    chk("nsv fetch", 32'(fetch_allow0), 1);
    chk("nsv wait", 32'(cpu_wait0), 1);
    tick(4);
    chk("sv cpu ack", 32'(cpu_ack), 1);
    chk("sv rdata", 32'(rdata), 32'h5A);
    chk("nsv no ack", 32'(cpu_ack0), 0);
    chk("nsv wait held", 32'(cpu_wait0), 1);

    // CPU and AUX both held, screen idle: alternate starting with CPU
    scr_req = 0; aux_req = 1; aux_wr = 0; aux_addr = 19'h7FFFF;
    tick(4);
    chk("rr ra cpu", 32'(ra), 32'h0ABCD);
    chk("rr fetch off", 32'(fetch_allow), 0);
    tick(4);
    chk("rr1 acks", {30'b0, cpu_ack, aux_ack}, 32'b10);
    chk("rr ra aux", 32'(ra), 32'h7FFFF);
    tick(4);
    chk("rr2 acks", {30'b0, cpu_ack, aux_ack}, 32'b01);
    tick(4);
    chk("rr3 acks", {30'b0, cpu_ack, aux_ack}, 32'b10);
    tick(4);
    chk("rr4 acks", {30'b0, cpu_ack, aux_ack}, 32'b01);
    // CPU was granted on that edge; dropping the request now must not cancel it
    cpu_req = 0; aux_req = 0;
    tick(4);
    chk("drop ack", 32'(cpu_ack), 1);

    // Reset during phase 1 of a write slot
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h00ABC; cpu_wdata = 8'hC3;
    tick(4);
    chk("mr rd_oe", 32'(rd_oe), 1);
    tick(1);
    chk("mr we_n ph1", 32'(ram_we_n), 0);
    rst_n = 0; cpu_req = 0; cpu_wr = 0;
    #1;
    chk("mr we_n rst", 32'(ram_we_n), 1);
    chk("mr rd_oe rst", 32'(rd_oe), 0);
    chk("mr ra rst", 32'(ra), 0);
    tick(2);
    rst_n = 1;
    cpu_req = 1; cpu_addr = 19'h00077;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("mr no ack", 32'(cpu_ack), 0);
      chk("mr no grant", 32'(ram_oe_n), 1);
    end
    tick(1);
    chk("mr grant oe_n", 32'(ram_oe_n), 0);
    chk("mr grant ra", 32'(ra), 32'h77);
    chk("mr ack late", 32'(cpu_ack), 0);
    tick(4);
    chk("mr ack", 32'(cpu_ack), 1);
    cpu_req = 0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
